// File: rtl/vga_ddr_fetch_if.sv
// DDR user read port as seen by the VGA fetch stage: burst request/ack plus
// the returning 128-bit data beats.
interface vga_ddr_fetch_if #(
  parameter int ADDR_W = 28
);
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_ack;
  logic              mem_rd_valid;
  logic [127:0]      mem_rd_data;

  modport master (
    output mem_rd_req,
    output mem_rd_addr,
    input  mem_rd_ack,
    input  mem_rd_valid,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_req,
    input  mem_rd_addr,
    output mem_rd_ack,
    output mem_rd_valid,
    output mem_rd_data
  );
endinterface

// File: rtl/vga_ddr_fetch.sv
// VGA frame fetcher: one fixed-length DDR burst per display command, buffered
// in a show-ahead FIFO of 128-bit pixel words (8 x RGB565 each).
module vga_ddr_fetch #(
  parameter int ADDR_W      = 28,
  parameter int BASE_ADDR   = 0,
  parameter int BURST_LEN   = 64,
  parameter int FRAME_WORDS = 98304,
  parameter int FIFO_DEPTH  = 256
) (
  input  logic                        vga_clk,
  input  logic                        vga_rst_n,
  input  logic                        ddr_addr_set,
  input  logic                        ddr_rd_cmd,
  input  logic                        ddr_rden,
  output logic [127:0]                ddr_data,
  vga_ddr_fetch_if.master             mem,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underflow,
  output logic                        cmd_overrun
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int FRM_W  = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RECV  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                req_r;
  logic                req_nxt_s;
  logic                pending_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [FRM_W-1:0]    frame_cnt_r;
  logic [BEAT_W-1:0]   beat_cnt_r;
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [LVL_W-1:0]    level_r;
  logic [127:0]        data_r;
  logic                underflow_r;
  logic                overrun_r;
  logic [127:0]        fifo_mem_r [FIFO_DEPTH];

  logic                beat_s;
  logic                last_beat_s;
  logic                full_s;
  logic                empty_s;
  logic                push_s;
  logic                push_drop_s;
  logic                pop_s;
  logic                start_s;
  logic                burst_done_s;
  logic [LVL_W-1:0]    free_s;
  logic [FRM_W-1:0]    frame_sum_s;
  logic                frame_wrap_s;
  logic [PTR_W-1:0]    rd_ptr_nxt_s;
  logic [LVL_W-1:0]    level_nxt_s;
  logic [127:0]        head_nxt_s;

  // Only one burst is ever outstanding, so in IDLE nothing is in flight and
  // the free space is simply the unused FIFO depth.
  assign free_s       = LVL_W'(FIFO_DEPTH) - level_r;
  assign empty_s      = (level_r == {LVL_W{1'b0}});
  assign full_s       = (level_r == LVL_W'(FIFO_DEPTH));
  assign start_s      = (state_r == ST_IDLE) && pending_r && !ddr_addr_set &&
                        (free_s >= LVL_W'(BURST_LEN));
  assign beat_s       = mem.mem_rd_valid && ((state_r == ST_RECV) || (state_r == ST_DRAIN));
  assign last_beat_s  = beat_s && (beat_cnt_r == BEAT_W'(BURST_LEN - 1));
  assign push_s       = (state_r == ST_RECV) && mem.mem_rd_valid && !ddr_addr_set && !full_s;
  assign push_drop_s  = (state_r == ST_RECV) && mem.mem_rd_valid && !ddr_addr_set && full_s;
  assign pop_s        = ddr_rden && !empty_s && !ddr_addr_set;
  assign burst_done_s = (state_r == ST_RECV) && last_beat_s && !ddr_addr_set;
  assign frame_sum_s  = frame_cnt_r + FRM_W'(BURST_LEN);
  assign frame_wrap_s = (frame_sum_s == FRM_W'(FRAME_WORDS));
  assign rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;

  // Burst sequencing; a frame restart mid-burst must still swallow the
  // beats the memory has already committed to, hence DRAIN.
  always_comb begin
    state_nxt_s = state_r;
    req_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = ST_REQ;
          req_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem.mem_rd_ack) begin
          state_nxt_s = ddr_addr_set ? ST_DRAIN : ST_RECV;
        end else if (ddr_addr_set) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ;
          req_nxt_s   = 1'b1;
        end
      end
      ST_RECV: begin
        if (last_beat_s) begin
          state_nxt_s = ST_IDLE;
        end else if (ddr_addr_set) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RECV;
        end
      end
      ST_DRAIN: begin
        if (last_beat_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        req_nxt_s   = 1'b0;
      end
    endcase
  end

  // FSM state and registered request.
  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      state_r <= ST_IDLE;
      req_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      req_r   <= req_nxt_s;
    end
  end

  // Command capture; a command arriving with the flush survives it.
  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      pending_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (ddr_addr_set) begin
        pending_r <= ddr_rd_cmd;
      end else if (ddr_rd_cmd && !pending_r) begin
        pending_r <= 1'b1;
      end else if (start_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
      if ((ddr_rd_cmd && pending_r && !ddr_addr_set) || push_drop_s) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  // Beat counter, shared by RECV and DRAIN.
  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      beat_cnt_r <= {BEAT_W{1'b0}};
    end else if (state_r == ST_REQ) begin
      beat_cnt_r <= {BEAT_W{1'b0}};
    end else if (beat_s) begin
      beat_cnt_r <= last_beat_s ? {BEAT_W{1'b0}} : (beat_cnt_r + BEAT_W'(1));
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  // Burst address walks the frame and wraps to the base after the last burst.
  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      addr_r      <= ADDR_W'(BASE_ADDR);
      frame_cnt_r <= {FRM_W{1'b0}};
    end else if (ddr_addr_set) begin
      addr_r      <= ADDR_W'(BASE_ADDR);
      frame_cnt_r <= {FRM_W{1'b0}};
    end else if (burst_done_s) begin
      if (frame_wrap_s) begin
        addr_r      <= ADDR_W'(BASE_ADDR);
        frame_cnt_r <= {FRM_W{1'b0}};
      end else begin
        addr_r      <= addr_r + ADDR_W'(BURST_LEN);
        frame_cnt_r <= frame_sum_s;
      end
    end else begin
      addr_r      <= addr_r;
      frame_cnt_r <= frame_cnt_r;
    end
  end

  // Next head word; a beat landing in the head slot this cycle is bypassed.
  always_comb begin
    level_nxt_s = level_r;
    head_nxt_s  = data_r;
    if (ddr_addr_set) begin
      level_nxt_s = {LVL_W{1'b0}};
    end else if (push_s && !pop_s) begin
      level_nxt_s = level_r + LVL_W'(1);
    end else if (pop_s && !push_s) begin
      level_nxt_s = level_r - LVL_W'(1);
    end else begin
      level_nxt_s = level_r;
    end
    if (ddr_addr_set) begin
      head_nxt_s = 128'd0;
    end else if (level_nxt_s == {LVL_W{1'b0}}) begin
      head_nxt_s = data_r;
    end else if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      head_nxt_s = mem.mem_rd_data;
    end else begin
      head_nxt_s = fifo_mem_r[rd_ptr_nxt_s];
    end
  end

  // FIFO pointers, occupancy, registered head and underflow flag.
  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      level_r     <= {LVL_W{1'b0}};
      data_r      <= 128'd0;
      underflow_r <= 1'b0;
    end else begin
      if (ddr_addr_set) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
        wr_ptr_r <= push_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
        rd_ptr_r <= rd_ptr_nxt_s;
      end
      level_r <= level_nxt_s;
      data_r  <= head_nxt_s;
      if (ddr_rden && empty_s) begin
        underflow_r <= 1'b1;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

  // FIFO storage needs no reset; the level guards its contents.
  always_ff @(posedge vga_clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= mem.mem_rd_data;
    end
  end

  assign mem.mem_rd_req  = req_r;
  assign mem.mem_rd_addr = addr_r;
  assign ddr_data        = data_r;
  assign fifo_level      = level_r;
  assign underflow       = underflow_r;
  assign cmd_overrun     = overrun_r;

endmodule

// File: tb/tb_vga_ddr_fetch.sv
// Bench for vga_ddr_fetch: queue-based FIFO/burst reference model, a DDR
// responder, a table of post-reset vectors and directed multi-cycle sequences.
module tb_vga_ddr_fetch;
  localparam int AW    = 28;
  localparam int BASE  = 0;
  localparam int BURST = 64;
  localparam int FRAME = 640;
  localparam int DEPTH = 256;

  logic         vga_clk = 1'b0;
  logic         vga_rst_n;
  logic         ddr_addr_set;
  logic         ddr_rd_cmd;
  logic         ddr_rden;
  logic [127:0] ddr_data;
  logic [8:0]   fifo_level;
  logic         underflow;
  logic         cmd_overrun;

  always #5 vga_clk = ~vga_clk;

  vga_ddr_fetch_if #(.ADDR_W(AW)) dif ();

  vga_ddr_fetch #(
    .ADDR_W(AW), .BASE_ADDR(BASE), .BURST_LEN(BURST),
    .FRAME_WORDS(FRAME), .FIFO_DEPTH(DEPTH)
  ) dut (
    .vga_clk(vga_clk), .vga_rst_n(vga_rst_n), .ddr_addr_set(ddr_addr_set),
    .ddr_rd_cmd(ddr_rd_cmd), .ddr_rden(ddr_rden), .ddr_data(ddr_data),
    .mem(dif.master), .fifo_level(fifo_level), .underflow(underflow),
    .cmd_overrun(cmd_overrun)
  );

  int checks = 0;
  int errors = 0;

  // reference model: FIFO as a queue, burst progress as beat counts
  logic [127:0] mq[$];
  logic [127:0] m_data;
  bit m_pend, m_req, m_und, m_ovr;
  int m_recv, m_drain, m_words;

  // DDR responder
  bit r_en, rnd_dly, auto_pop;
  int r_left, r_wait, r_dly, r_vprob;
  int acks[$];
  logic [127:0] sent[$];

  typedef struct {
    bit cmd; bit set; bit rden;
    bit req; int lvl; bit und; bit ovr;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    chk("level", fifo_level, mq.size());
    chk("data", ddr_data, m_data);
    chk("req", dif.mem_rd_req, m_req);
    chk("addr", dif.mem_rd_addr, BASE + m_words);
    chk("underflow", underflow, m_und);
    chk("overrun", cmd_overrun, m_ovr);
  endtask

  task automatic step(input bit cmd, input bit set, input bit rden);
    bit ack, vld, old_p, busy, start;
    logic [127:0] vd;
    int pre_size, n;
    ack = 1'b0; vld = 1'b0; vd = 128'd0;
    if (r_left > 0) begin
      if ($urandom_range(99) < r_vprob) begin
        vld = 1'b1;
        vd = {$urandom(), $urandom(), $urandom(), $urandom()};
        sent.push_back(vd);
        r_left--;
      end
    end else if (r_en && dif.mem_rd_req) begin
      if (r_wait == 0) begin
        ack = 1'b1;
        r_left = BURST;
        acks.push_back(int'(dif.mem_rd_addr));
        r_wait = rnd_dly ? int'($urandom_range(4)) : r_dly;
      end else begin
        r_wait--;
      end
    end else begin
      r_wait = rnd_dly ? int'($urandom_range(4)) : r_dly;
    end
    ddr_rd_cmd = cmd; ddr_addr_set = set; ddr_rden = rden;
    dif.mem_rd_ack = ack; dif.mem_rd_valid = vld; dif.mem_rd_data = vd;

    pre_size = mq.size();
    old_p = m_pend;
    busy  = m_req || (m_recv > 0) || (m_drain > 0);
    start = !busy && m_pend && ((DEPTH - pre_size) >= BURST) && !set;
    if (rden && pre_size == 0) m_und = 1'b1;
    if (set) begin
      mq.delete(); m_words = 0; m_data = 128'd0;
      if (m_req) begin
        if (ack) m_drain = BURST;
        m_req = 1'b0;
      end else if (m_recv > 0) begin
        n = m_recv - (vld ? 1 : 0);
        m_recv = 0; m_drain = n;
      end else if (m_drain > 0 && vld) begin
        m_drain--;
      end
      m_pend = cmd;
    end else begin
      if (rden && pre_size > 0) void'(mq.pop_front());
      if (m_req && ack) begin
        m_req = 1'b0; m_recv = BURST;
      end else if (m_recv > 0 && vld) begin
        if (pre_size >= DEPTH) m_ovr = 1'b1;
        else mq.push_back(vd);
        m_recv--;
        if (m_recv == 0) m_words = (m_words + BURST) % FRAME;
      end else if (m_drain > 0 && vld) begin
        m_drain--;
      end
      if (start) begin m_req = 1'b1; m_pend = 1'b0; end
      if (cmd) begin
        if (old_p) m_ovr = 1'b1;
        else m_pend = 1'b1;
      end
      if (mq.size() > 0) m_data = mq[0];
    end
    @(posedge vga_clk);
    #1;
    check_model();
  endtask

  task automatic tick(input bit cmd, input bit set);
    step(cmd, set, auto_pop && (mq.size() > 0));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while ((m_req || m_recv > 0 || m_drain > 0 || m_pend) && k < budget) begin
      tick(1'b0, 1'b0);
      k++;
    end
    chk({name, " timeout"}, (k >= budget), 1'b0);
  endtask

  task automatic reset_all();
    vga_rst_n = 1'b0;
    ddr_addr_set = 1'b0; ddr_rd_cmd = 1'b0; ddr_rden = 1'b0;
    dif.mem_rd_ack = 1'b0; dif.mem_rd_valid = 1'b0; dif.mem_rd_data = 128'd0;
    mq.delete(); m_data = 128'd0;
    m_pend = 1'b0; m_req = 1'b0; m_und = 1'b0; m_ovr = 1'b0;
    m_recv = 0; m_drain = 0; m_words = 0;
    r_left = 0; r_wait = r_dly; acks.delete(); sent.delete();
    repeat (2) @(posedge vga_clk);
    #1 vga_rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // {cmd, set, rden} -> {req, level, underflow, overrun}; responder silent
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1};

    r_dly = 3; r_vprob = 100; rnd_dly = 1'b0; auto_pop = 1'b0; r_en = 1'b0;
    reset_all();
    chk("reset req", dif.mem_rd_req, 1'b0);
    chk("reset addr", dif.mem_rd_addr, BASE);
    chk("reset data", ddr_data, 128'd0);
    chk("reset level", fifo_level, 9'd0);
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].cmd, tbl[i].set, tbl[i].rden);
      chk($sformatf("tbl%0d req", i), dif.mem_rd_req, tbl[i].req);
      chk($sformatf("tbl%0d level", i), fifo_level, tbl[i].lvl);
      chk($sformatf("tbl%0d underflow", i), underflow, tbl[i].und);
      chk($sformatf("tbl%0d overrun", i), cmd_overrun, tbl[i].ovr);
      chk($sformatf("tbl%0d data", i), ddr_data, 128'd0);
    end

    // single burst, then drain it in order
    r_en = 1'b1;
    reset_all();
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    wait_idle("A burst", 200);
    chk("A ack addr", acks[0], BASE);
    chk("A level", fifo_level, 9'd64);
    chk("A head beat0", ddr_data, sent[0]);
    for (int i = 0; i < BURST; i++) begin
      chk("A pop order", ddr_data, sent[i]);
      step(1'b0, 1'b0, 1'b1);
    end
    chk("A level empty", fifo_level, 9'd0);
    chk("A underflow", underflow, 1'b0);

    // back-to-back fills until the space check holds a command
    reset_all();
    tick(1'b1, 1'b0);
    repeat (650) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (650) tick(1'b0, 1'b0);
    chk("B level 128", fifo_level, 9'd128);
    chk("B second addr", acks[1], BASE + 64);
    tick(1'b1, 1'b0); wait_idle("B third", 300);
    chk("B level 192", fifo_level, 9'd192);
    tick(1'b1, 1'b0); wait_idle("B fourth", 300);
    chk("B level 256", fifo_level, 9'd256);
    tick(1'b1, 1'b0);
    repeat (100) tick(1'b0, 1'b0);
    chk("B held bursts", acks.size(), 4);
    for (int i = 0; i < BURST; i++) step(1'b0, 1'b0, 1'b1);
    wait_idle("B released", 300);
    chk("B fifth addr", acks[4], BASE + 256);
    chk("B overrun", cmd_overrun, 1'b0);

    // command overrun while busy
    reset_all();
    auto_pop = 1'b1;
    tick(1'b1, 1'b0);
    repeat (4) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    wait_idle("C bursts", 400);
    chk("C overrun", cmd_overrun, 1'b1);
    chk("C burst count", acks.size(), 2);

    // frame wrap: the burst after a full frame restarts at the base
    reset_all();
    tick(1'b0, 1'b1);
    for (int b = 0; b <= FRAME / BURST; b++) begin
      tick(1'b1, 1'b0);
      wait_idle("D burst", 300);
    end
    for (int b = 0; b <= FRAME / BURST; b++)
      chk($sformatf("D addr%0d", b), acks[b], BASE + (b * BURST) % FRAME);

    // frame restart at beat 20 discards the rest of the burst
    reset_all();
    auto_pop = 1'b0;
    tick(1'b1, 1'b0);
    k = 0;
    while (mq.size() < 20 && k < 200) begin tick(1'b0, 1'b0); k++; end
    chk("E reach beat 20", fifo_level, 9'd20);
    tick(1'b0, 1'b1);
    chk("E flushed", fifo_level, 9'd0);
    wait_idle("E drain", 200);
    chk("E all beats sent", sent.size(), 64);
    chk("E still empty", fifo_level, 9'd0);
    tick(1'b1, 1'b0);
    wait_idle("E refetch", 200);
    chk("E new addr", acks[1], BASE);
    chk("E new level", fifo_level, 9'd64);
    chk("E new head", ddr_data, sent[64]);

    // asynchronous reset in the middle of a burst
    reset_all();
    tick(1'b1, 1'b0);
    k = 0;
    while (mq.size() < 10 && k < 200) begin tick(1'b0, 1'b0); k++; end
    #2 vga_rst_n = 1'b0;
    #1;
    chk("R req", dif.mem_rd_req, 1'b0);
    chk("R addr", dif.mem_rd_addr, BASE);
    chk("R data", ddr_data, 128'd0);
    chk("R level", fifo_level, 9'd0);
    chk("R underflow", underflow, 1'b0);
    chk("R overrun", cmd_overrun, 1'b0);

    // random traffic against the model
    rnd_dly = 1'b1; r_vprob = 70;
    reset_all();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) < 4, $urandom_range(999) < 4, $urandom_range(99) < 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
